// File: rtl/scan_pkg.sv
// Shared definitions for the column-scan trigger generator: pattern mode
// encodings, parameter-word field positions and sequence counter constants.
package scan_pkg;

  // Column pattern advance modes, selected by the parameter word.
  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_WALK_L = 2'd1,
    MODE_WALK_R = 2'd2,
    MODE_BOUNCE = 2'd3
  } scan_mode_e;

  // Parameter word field positions.
  localparam int PRM_ACTIVE  = 26;
  localparam int PRM_MODE_HI = 25;
  localparam int PRM_MODE_LO = 24;

  // Strobe sequence counter: 4 bits, parked at 15 when idle.
  localparam int               SEQ_W    = 4;
  localparam logic [SEQ_W-1:0] SEQ_IDLE = 4'd15;

  // Extract the mode field from a parameter word.
  function automatic scan_mode_e prm_mode(input logic [31:0] word);
    return scan_mode_e'(word[PRM_MODE_HI:PRM_MODE_LO]);
  endfunction

endpackage

// File: rtl/scan_pattern_shifter.sv
// Column pattern register with per-mode initial load and once-per-frame
// advance (static, rotate left, rotate right, ping-pong bounce).
module scan_pattern_shifter
  import scan_pkg::*;
#(
  parameter int COLS = 28
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  scan_mode_e      i_mode,
  input  logic            i_shift,
  output logic [COLS-1:0] o_pattern
);

  logic [COLS-1:0] pattern_q, pattern_d;
  // Bounce direction: 1 = moving towards the MSB, 0 = towards bit 0.
  logic            dir_up_q, dir_up_d;

  logic [COLS-1:0] rot_left;
  logic [COLS-1:0] rot_right;
  logic [COLS-1:0] shift_left;
  logic [COLS-1:0] shift_right;

  assign rot_left    = {pattern_q[COLS-2:0], pattern_q[COLS-1]};
  assign rot_right   = {pattern_q[0], pattern_q[COLS-1:1]};
  assign shift_left  = {pattern_q[COLS-2:0], 1'b0};
  assign shift_right = {1'b0, pattern_q[COLS-1:1]};

  // Next pattern: a load always wins over a frame advance.
  always_comb begin
    pattern_d = pattern_q;
    dir_up_d  = dir_up_q;
    if (i_load) begin
      dir_up_d = 1'b0;
      case (i_mode)
        MODE_STATIC: pattern_d = '1;
        MODE_WALK_L: begin
          pattern_d           = '0;
          pattern_d[COLS-1]   = 1'b1;
        end
        MODE_WALK_R: begin
          pattern_d           = '0;
          pattern_d[0]        = 1'b1;
        end
        default: begin
          // Bounce starts one step in from bit 0 heading down, so the
          // first frame shows bit 0 and the sweep then climbs.
          pattern_d           = '0;
          pattern_d[1]        = 1'b1;
        end
      endcase
    end else if (i_shift) begin
      case (i_mode)
        MODE_STATIC: pattern_d = pattern_q;
        MODE_WALK_L: pattern_d = rot_left;
        MODE_WALK_R: pattern_d = rot_right;
        default: begin
          if (dir_up_q) begin
            if (pattern_q[COLS-1]) begin
              dir_up_d  = 1'b0;
              pattern_d = shift_right;
            end else begin
              pattern_d = shift_left;
            end
          end else begin
            if (pattern_q[0]) begin
              dir_up_d  = 1'b1;
              pattern_d = shift_left;
            end else begin
              pattern_d = shift_right;
            end
          end
        end
      endcase
    end
  end

  // Pattern and direction state registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pattern_q <= '0;
      dir_up_q  <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      dir_up_q  <= dir_up_d;
    end
  end

  assign o_pattern = pattern_q;

endmodule

// File: rtl/scan_trigger_gen.sv
// Column-scan trigger generator: divides the clock into row periods, runs a
// blank/toggle/load strobe sequence each row and advances the column pattern
// once per frame.
module scan_trigger_gen
  import scan_pkg::*;
#(
  parameter int  COLS     = 28,
  parameter int  ROWS     = 32,
  parameter int  DIV_W    = 24,
  parameter int  DIV_MIN  = 1023,
  parameter int  T_BLANK  = 1,
  parameter int  T_TOGGLE = 6,
  parameter int  T_LOAD   = 14,
  localparam int ROW_W    = $clog2(ROWS)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ena,
  input  logic             i_prm_we,
  input  logic [31:0]      i_prm,
  output logic [COLS-1:0]  o_col_pattern,
  output logic             o_toggle_sync,
  output logic             o_head_flag,
  output logic [ROW_W-1:0] o_row
);

  localparam logic [DIV_W-1:0] PERIOD_MIN = DIV_W'(DIV_MIN);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);
  localparam logic [SEQ_W-1:0] SEQ_BLANK  = SEQ_W'(T_BLANK);
  localparam logic [SEQ_W-1:0] SEQ_TOGGLE = SEQ_W'(T_TOGGLE);
  localparam logic [SEQ_W-1:0] SEQ_LOAD   = SEQ_W'(T_LOAD);

  // ---------------- parameter register ----------------
  logic             active_q, active_d;
  scan_mode_e       mode_q, mode_d;
  logic [DIV_W-1:0] period_q, period_d;
  logic             prm_update_q;
  logic             unused_prm_bits;

  // Only the active, mode and period fields are meaningful.
  assign unused_prm_bits = ^i_prm;

  // Capture a parameter write; short periods are raised to the legal minimum.
  always_comb begin
    active_d = active_q;
    mode_d   = mode_q;
    period_d = period_q;
    if (i_prm_we) begin
      active_d = i_prm[PRM_ACTIVE];
      mode_d   = prm_mode(i_prm);
      period_d = (i_prm[DIV_W-1:0] < PERIOD_MIN) ? PERIOD_MIN : i_prm[DIV_W-1:0];
    end
  end

  // Parameter registers and the one-cycle update pulse that follows a write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      active_q     <= 1'b0;
      mode_q       <= MODE_STATIC;
      period_q     <= PERIOD_MIN;
      prm_update_q <= 1'b0;
    end else begin
      active_q     <= active_d;
      mode_q       <= mode_d;
      period_q     <= period_d;
      prm_update_q <= i_prm_we;
    end
  end

  // ---------------- enable edge detect ----------------
  logic ena_q;
  logic start;

  // Reset to 1 so an enable already high at reset release is not an edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ena_q <= 1'b1;
    end else begin
      ena_q <= i_ena;
    end
  end

  assign start = i_ena & ~ena_q;

  // ---------------- row divider ----------------
  logic [DIV_W-1:0] div_q, div_d;
  logic             count_end;
  logic             sync;

  assign count_end = (div_q == period_q);
  // A start coinciding with count_end still yields only one sync.
  assign sync      = count_end | start;

  // Divider is held at zero while disabled and restarts on every row sync.
  always_comb begin
    if (prm_update_q || !ena_q || sync) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // ---------------- sequence and row counters ----------------
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             frame_sync;

  // Sequence restarts on sync and parks at idle; a write aborts it.
  always_comb begin
    seq_d = seq_q;
    if (prm_update_q) begin
      seq_d = SEQ_IDLE;
    end else if (sync) begin
      seq_d = '0;
    end else if (seq_q != SEQ_IDLE) begin
      seq_d = seq_q + SEQ_W'(1);
    end
  end

  // Row index advances on sync; a write parks it on the last row so the
  // next sync begins a fresh frame at row 0.
  always_comb begin
    row_d = row_q;
    if (prm_update_q) begin
      row_d = ROW_LAST;
    end else if (sync) begin
      row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
    end
  end

  assign frame_sync = sync & (row_q == ROW_LAST);

  // Divider, sequence and row state registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div_q <= '0;
      seq_q <= SEQ_IDLE;
      row_q <= ROW_LAST;
    end else begin
      div_q <= div_d;
      seq_q <= seq_d;
      row_q <= row_d;
    end
  end

  // ---------------- pattern ----------------
  logic [COLS-1:0] pattern;

  scan_pattern_shifter #(
    .COLS (COLS)
  ) u_shifter (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (prm_update_q),
    .i_mode    (mode_q),
    .i_shift   (frame_sync & ~prm_update_q),
    .o_pattern (pattern)
  );

  // ---------------- strobe outputs ----------------
  logic [COLS-1:0]  col_q, col_d;
  logic             tog_q, tog_d;
  logic             head_q, head_d;
  logic [ROW_W-1:0] row_out_q, row_out_d;

  // Strobes are decoded from the next sequence value so each output changes
  // in the same cycle the sequence counter shows the matching step.
  always_comb begin
    col_d     = col_q;
    tog_d     = tog_q;
    head_d    = head_q;
    row_out_d = row_out_q;
    if (seq_d == SEQ_BLANK) begin
      col_d     = '0;
      head_d    = (row_q == '0);
      row_out_d = row_q;
    end
    if (seq_d == SEQ_TOGGLE) begin
      tog_d = ~tog_q;
    end
    if (seq_d == SEQ_LOAD) begin
      col_d = active_q ? pattern : '0;
    end
  end

  // Output registers; they hold their values whenever the sequence is idle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col_q     <= '0;
      tog_q     <= 1'b0;
      head_q    <= 1'b0;
      row_out_q <= ROW_LAST;
    end else begin
      col_q     <= col_d;
      tog_q     <= tog_d;
      head_q    <= head_d;
      row_out_q <= row_out_d;
    end
  end

  assign o_col_pattern = col_q;
  assign o_toggle_sync = tog_q;
  assign o_head_flag   = head_q;
  assign o_row         = row_out_q;

endmodule

// File: tb/tb_scan_trigger_gen.sv
// Scoreboard bench for scan_trigger_gen (COLS=4, ROWS=2, DIV_MIN=20).
// Stimulus pushes the expected output snapshots with their cycle numbers;
// the monitor pops one whenever the outputs change or an entry falls due.
module tb_scan_trigger_gen;

  localparam int K_LEVEL  = 0;
  localparam int K_BLANK  = 1;
  localparam int K_TOGGLE = 2;
  localparam int K_LOAD   = 3;
  localparam int K_RESET  = 4;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_ena;
  logic        i_prm_we;
  logic [31:0] i_prm;
  logic [3:0]  o_col_pattern;
  logic        o_toggle_sync;
  logic        o_head_flag;
  logic [0:0]  o_row;

  scan_trigger_gen #(
    .COLS     (4),
    .ROWS     (2),
    .DIV_W    (24),
    .DIV_MIN  (20),
    .T_BLANK  (1),
    .T_TOGGLE (6),
    .T_LOAD   (14)
  ) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_ena         (i_ena),
    .i_prm_we      (i_prm_we),
    .i_prm         (i_prm),
    .o_col_pattern (o_col_pattern),
    .o_toggle_sync (o_toggle_sync),
    .o_head_flag   (o_head_flag),
    .o_row         (o_row)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    int         kind;
    logic [3:0] col;
    logic       tog;
    logic       head;
    logic       row;
  } ev_t;

  ev_t exp_q[$];

  int   errors = 0;
  int   checks = 0;
  logic mon_en = 1'b0;
  logic finish_req = 1'b0;

  // Hand-computed per-frame patterns.
  logic [3:0] walk_tab   [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] bounce_tab [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                 4'b0100, 4'b0010, 4'b0001, 4'b0010};

  // Expected output state.
  logic [3:0] m_col;
  logic       m_tog;
  logic       m_head;
  logic       m_row;

  function automatic string kind_name(int k);
    case (k)
      K_LEVEL:  return "level";
      K_BLANK:  return "blank";
      K_TOGGLE: return "toggle";
      K_LOAD:   return "load";
      default:  return "reset";
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(int t);
    while (cyc < t) step();
  endtask

  task automatic model_reset();
    m_col  = 4'd0;
    m_tog  = 1'b0;
    m_head = 1'b0;
    m_row  = 1'b1;
  endtask

  task automatic expect_now(int c, int kind);
    ev_t e;
    e.c    = c;
    e.kind = kind;
    e.col  = m_col;
    e.tog  = m_tog;
    e.head = m_head;
    e.row  = m_row;
    exp_q.push_back(e);
  endtask

  task automatic model_step(int c, int kind, logic [3:0] col, logic tog, logic head, logic row);
    if (col !== m_col || tog !== m_tog || head !== m_head || row !== m_row) begin
      m_col  = col;
      m_tog  = tog;
      m_head = head;
      m_row  = row;
      expect_now(c, kind);
    end
  endtask

  // One row whose sync happens in cycle s: blank +2, toggle +7, load +15.
  task automatic push_row(int s, logic row, logic [3:0] pat, logic active);
    model_step(s + 2,  K_BLANK,  4'd0, m_tog, (row == 1'b0), row);
    model_step(s + 7,  K_TOGGLE, m_col, ~m_tog, m_head, m_row);
    model_step(s + 15, K_LOAD,   active ? pat : 4'd0, m_tog, m_head, m_row);
  endtask

  task automatic write_prm(logic act, logic [1:0] mode, int period);
    i_prm    = {5'b0, act, mode, 24'(period)};
    i_prm_we = 1'b1;
    step();
    i_prm_we = 1'b0;
    i_prm    = 32'd0;
  endtask

  // Monitor / scoreboard.
  initial begin : monitor
    logic [3:0] p_col;
    logic       p_tog;
    logic       p_head;
    logic       p_row;
    logic       changed;
    logic       due;
    ev_t        e;
    p_col  = 'x;
    p_tog  = 'x;
    p_head = 'x;
    p_row  = 'x;
    forever begin
      @(negedge clk);
      if (finish_req) begin
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL queue_drain: %0d expected events left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
      changed = (o_col_pattern !== p_col) || (o_toggle_sync !== p_tog) ||
                (o_head_flag !== p_head) || (o_row !== p_row);
      if (mon_en) begin
        due = (exp_q.size() > 0) && (cyc >= exp_q[0].c);
        if (changed || due) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change @%0d: got col=%b tog=%b head=%b row=%0d, required no change",
                     cyc, o_col_pattern, o_toggle_sync, o_head_flag, o_row);
          end else begin
            e = exp_q.pop_front();
            if (e.c != cyc || o_col_pattern !== e.col || o_toggle_sync !== e.tog ||
                o_head_flag !== e.head || o_row !== e.row) begin
              errors++;
              $display("FAIL %s: got @%0d col=%b tog=%b head=%b row=%0d, required @%0d col=%b tog=%b head=%b row=%0d",
                       kind_name(e.kind), cyc, o_col_pattern, o_toggle_sync, o_head_flag, o_row,
                       e.c, e.col, e.tog, e.head, e.row);
            end else begin
              $display("ok %s @%0d col=%b tog=%b head=%b row=%0d",
                       kind_name(e.kind), cyc, o_col_pattern, o_toggle_sync, o_head_flag, o_row);
            end
          end
        end
      end
      p_col  = o_col_pattern;
      p_tog  = o_toggle_sync;
      p_head = o_head_flag;
      p_row  = o_row;
    end
  end

  // Stimulus.
  initial begin : stimulus
    int w;
    int s0;
    int d;
    int k;
    i_rst    = 1'b1;
    i_ena    = 1'b1;
    i_prm_we = 1'b0;
    i_prm    = 32'd0;
    model_reset();
    repeat (3) step();
    i_rst  = 1'b0;
    mon_en = 1'b1;

    // Reset values hold after release with enable already high.
    expect_now(cyc + 1, K_LEVEL);
    expect_now(cyc + 4, K_LEVEL);
    wait_until(cyc + 5);

    // Walk-left, period 5 clamped to 20 -> 21-cycle rows.
    w  = cyc;
    s0 = w + 2 + 20;
    for (int j = 0; j < 10; j++)
      push_row(s0 + 21 * j, (j % 2) == 1, walk_tab[j / 2], 1'b1);
    write_prm(1'b1, 2'd1, 5);

    // Bounce, period 0 clamped to 20.
    wait_until(s0 + 21 * 9 + 16);
    w  = cyc;
    s0 = w + 2 + 20;
    for (int j = 0; j < 16; j++)
      push_row(s0 + 21 * j, (j % 2) == 1, bounce_tab[j / 2], 1'b1);
    write_prm(1'b1, 2'd3, 0);

    // Write lands so its update pulse coincides with count_end: no extra row.
    wait_until(s0 + 21 * 16 - 1);
    w  = cyc;
    s0 = w + 2 + 20;
    push_row(s0,      1'b0, 4'b1111, 1'b1);
    push_row(s0 + 21, 1'b1, 4'b1111, 1'b1);
    write_prm(1'b1, 2'd0, 20);

    // Disable after the last load, then re-enable mid-period.
    wait_until(s0 + 21 + 16);
    i_ena = 1'b0;
    d = cyc;
    wait_until(d + 10);
    k = cyc;
    push_row(k,      1'b0, 4'b1111, 1'b1);
    push_row(k + 21, 1'b1, 4'b1111, 1'b1);
    i_ena = 1'b1;

    // Inactive static pattern, period 25 (not clamped) -> 26-cycle rows.
    wait_until(k + 21 + 16);
    w  = cyc;
    s0 = w + 2 + 25;
    for (int j = 0; j < 3; j++)
      push_row(s0 + 26 * j, (j % 2) == 1, 4'b0000, 1'b0);
    write_prm(1'b0, 2'd0, 25);

    // Reset mid-operation while on row 0 with the toggle line high.
    wait_until(s0 + 26 * 2 + 16);
    model_step(cyc + 1, K_RESET, 4'd0, 1'b0, 1'b0, 1'b1);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    expect_now(cyc + 2, K_LEVEL);
    expect_now(cyc + 10, K_LEVEL);

    for (int n = 0; n < 300 && exp_q.size() > 0; n++) step();
    finish_req = 1'b1;
  end

endmodule
